instr_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory fetch port.
- Owns the program counter and drives the combinational byte-address port of the instruction memory.
- Captures the returned word into an IF/ID output register with a valid/ready handshake toward decode.
- Handles redirects from execute, flushes on redirect, and halts on fetch faults (misaligned or out-of-range address).

---
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction-memory address,
// captures fetched words into an IF/ID slot with a valid/ready handshake,
// and handles redirects, flushes and fault halts.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic [1:0]  if_err_o,
  output logic        halted_o,
  output logic [31:0] fetch_cnt_o
);

  localparam int unsigned PC_W      = 32;
  localparam logic [32:0] PC_LIMIT  = 33'(MEM_WORDS) << 2;
  localparam logic [1:0]  ERR_OK    = 2'b00;
  localparam logic [1:0]  ERR_ALIGN = 2'b01;
  localparam logic [1:0]  ERR_RANGE = 2'b10;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [PC_W-1:0] slot_pc_q, slot_pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [1:0]      err_q, err_d;
  logic            halted_q, halted_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [1:0]      fault;
  logic            slot_free;
  logic            handshake;

  assign imem_addr_o = pc_q;
  assign if_valid_o  = valid_q;
  assign if_pc_o     = slot_pc_q;
  assign if_instr_o  = instr_q;
  assign if_err_o    = err_q;
  assign halted_o    = halted_q;
  assign fetch_cnt_o = cnt_q;

  assign slot_free = !valid_q || id_ready_i;
  assign handshake = valid_q && id_ready_i;

  // Classify the current fetch address; alignment takes precedence over range.
  always_comb begin
    fault = ERR_OK;
    if (pc_q[1:0] != 2'b00) begin
      fault = ERR_ALIGN;
    end else if ({1'b0, pc_q} >= PC_LIMIT) begin
      fault = ERR_RANGE;
    end
  end

  // Next-state, PC and IF/ID slot update; redirect overrides everything else.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    slot_pc_d = slot_pc_q;
    instr_d   = instr_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    if (handshake) begin
      cnt_d = cnt_q + 32'd1;
    end

    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      err_d   = ERR_OK;
      state_d = ST_RUN;
    end else begin
      // A consumed slot empties unless a capture refills it below.
      if (handshake) begin
        valid_d = 1'b0;
      end
      unique case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (slot_free) begin
            valid_d   = 1'b1;
            slot_pc_d = pc_q;
            err_d     = fault;
            if (fault == ERR_OK) begin
              instr_d = imem_instr_i;
              pc_d    = pc_q + 32'd4;
            end else begin
              instr_d = NOP_INSTR;
              state_d = ST_HALT;
            end
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_BOOT;
      endcase
    end

    halted_d = (state_d == ST_HALT);
  end

  // State and slot registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      slot_pc_q <= '0;
      instr_q   <= NOP_INSTR;
      err_q     <= ERR_OK;
      halted_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      slot_pc_q <= slot_pc_d;
      instr_q   <= instr_d;
      err_q     <= err_d;
      halted_q  <= halted_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus randomized traffic,
// all checked against a transaction-level model of the fetch stream.
module tb_instr_fetch_unit;

  localparam int unsigned MEM_WORDS = 1024;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [1:0]  if_err;
  logic        halted;
  logic [31:0] fetch_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [MEM_WORDS];

  // Reference model: the PC to fetch next, the slot seen by decode, and a
  // phase (0 booting, 1 running, 2 halted).
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_spc;
  logic [31:0] m_instr;
  logic [1:0]  m_err;
  logic [31:0] m_cnt;
  int          m_phase;

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .MEM_WORDS(MEM_WORDS),
    .NOP_INSTR(NOP)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .imem_addr_o  (imem_addr),
    .imem_instr_i (imem_instr),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .id_ready_i   (id_ready),
    .if_valid_o   (if_valid),
    .if_pc_o      (if_pc),
    .if_instr_o   (if_instr),
    .if_err_o     (if_err),
    .halted_o     (halted),
    .fetch_cnt_o  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory; garbage beyond the end.
  always_comb begin
    if (imem_addr < 32'(MEM_WORDS * 4)) imem_instr = mem[imem_addr[11:2]];
    else                                imem_instr = 32'hBAD0_BAD0;
  end

  function automatic logic [1:0] fault_of(input logic [31:0] pc);
    if (pc % 4 != 0) return 2'd1;
    if (pc >= 32'(MEM_WORDS * 4)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [131:0] dut_vec();
    return {if_valid, if_pc, if_instr, if_err, halted, fetch_cnt, imem_addr};
  endfunction

  function automatic logic [131:0] model_vec();
    return {m_valid, m_spc, m_instr, m_err, (m_phase == 2), m_cnt, m_pc};
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_valid = 1'b0; m_spc = '0; m_instr = NOP;
    m_err = 2'd0; m_cnt = '0; m_phase = 0;
  endtask

  // Advance the model by one clock using the current inputs, then step the DUT.
  task automatic tick();
    logic took;
    logic [1:0] f;
    took = m_valid && id_ready;
    if (took) m_cnt = m_cnt + 32'd1;
    if (redirect) begin
      m_pc = redirect_pc; m_valid = 1'b0; m_instr = NOP; m_err = 2'd0; m_phase = 1;
    end else if (m_phase == 0) begin
      m_phase = 1;
      if (took) m_valid = 1'b0;
    end else if (m_phase == 2) begin
      if (took) m_valid = 1'b0;
    end else if (!m_valid || id_ready) begin
      f = fault_of(m_pc);
      m_valid = 1'b1; m_spc = m_pc; m_err = f;
      if (f == 2'd0) begin
        m_instr = mem[m_pc / 4];
        m_pc = m_pc + 32'd4;
      end else begin
        m_instr = NOP;
        m_phase = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    redirect = 1'b0; id_ready = 1'b1; redirect_pc = '0;
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++;
    if (dut_vec() !== {1'b0, 32'h0, NOP, 2'b00, 1'b0, 32'h0, RESET_PC}) begin
      bad++;
      $display("FAIL reset_values got=%h want=%h", dut_vec(),
               {1'b0, 32'h0, NOP, 2'b00, 1'b0, 32'h0, RESET_PC});
    end
  endtask

  task automatic test_program();
    logic [31:0] prog [4];
    prog[0] = 32'h0050_0093; prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_0013;
    do_reset();
    tick();
    total++;
    if (if_valid !== 1'b0 || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL boot_idle got=%h want=%h", dut_vec(), model_vec());
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_instr !== prog[i] ||
          dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL program_slot%0d got pc=%h instr=%h valid=%b want pc=%h instr=%h",
                 i, if_pc, if_instr, if_valid, 32'(i * 4), prog[i]);
      end
    end
    tick();
    total++;
    if (fetch_cnt !== 32'd4 || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL program_count got=%0d want=4", fetch_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (if_pc !== 32'h8 || if_valid !== 1'b1) begin
      bad++; $display("FAIL bp_setup got pc=%h valid=%b want pc=8 valid=1", if_pc, if_valid);
    end
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== mem[2] ||
          imem_addr !== 32'hC || dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL bp_hold%0d got pc=%h instr=%h addr=%h want pc=8 instr=%h addr=c",
                 i, if_pc, if_instr, imem_addr, mem[2]);
      end
    end
    id_ready = 1'b1;
    tick();
    total++;
    if (if_pc !== 32'hC || if_instr !== mem[3] || fetch_cnt !== 32'd3 ||
        dut_vec() !== model_vec()) begin
      bad++;
      $display("FAIL bp_release got pc=%h cnt=%0d want pc=c cnt=3", if_pc, fetch_cnt);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (if_pc !== 32'h10 || fetch_cnt !== 32'd4) begin
      bad++; $display("FAIL redir_setup got pc=%h cnt=%0d want pc=10 cnt=4", if_pc, fetch_cnt);
    end
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    total++;
    if (if_valid !== 1'b0 || fetch_cnt !== 32'd5 || imem_addr !== 32'h100 ||
        dut_vec() !== model_vec()) begin
      bad++;
      $display("FAIL redir_flush got valid=%b cnt=%0d addr=%h want valid=0 cnt=5 addr=100",
               if_valid, fetch_cnt, imem_addr);
    end
    tick();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== mem[64] ||
        dut_vec() !== model_vec()) begin
      bad++; $display("FAIL redir_target got pc=%h instr=%h want pc=100 instr=%h",
                      if_pc, if_instr, mem[64]);
    end
  endtask

  task automatic test_misaligned_halt();
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    tick();
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h102 || if_err !== 2'b01 ||
        if_instr !== NOP || halted !== 1'b1 || dut_vec() !== model_vec()) begin
      bad++;
      $display("FAIL misalign_slot got pc=%h err=%b instr=%h halted=%b want pc=102 err=01 instr=%h halted=1",
               if_pc, if_err, if_instr, halted, NOP);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (imem_addr !== 32'h102 || halted !== 1'b1 || if_valid !== 1'b0 ||
          dut_vec() !== model_vec()) begin
        bad++; $display("FAIL halt_frozen got addr=%h halted=%b valid=%b want addr=102 halted=1 valid=0",
                        imem_addr, halted, if_valid);
      end
    end
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    total++;
    if (halted !== 1'b0 || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL halt_exit got halted=%b want 0", halted);
    end
    tick();
    total++;
    if (if_pc !== 32'h40 || if_err !== 2'b00 || if_instr !== mem[16]) begin
      bad++; $display("FAIL halt_resume got pc=%h err=%b want pc=40 err=00", if_pc, if_err);
    end
  endtask

  task automatic test_out_of_range();
    redirect = 1'b1; redirect_pc = 32'hFF8;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    total++;
    if (if_pc !== 32'hFFC || if_err !== 2'b00 || if_instr !== mem[1023] ||
        dut_vec() !== model_vec()) begin
      bad++; $display("FAIL last_word got pc=%h err=%b instr=%h want pc=ffc err=00 instr=%h",
                      if_pc, if_err, if_instr, mem[1023]);
    end
    tick();
    total++;
    if (if_pc !== 32'h1000 || if_err !== 2'b10 || if_instr !== NOP ||
        halted !== 1'b1 || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL range_fault got pc=%h err=%b instr=%h halted=%b want pc=1000 err=10 halted=1",
                      if_pc, if_err, if_instr, halted);
    end
    tick();
    total++;
    if (imem_addr !== 32'h1000 || halted !== 1'b1 || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL range_frozen got addr=%h halted=%b want addr=1000 halted=1",
                      imem_addr, halted);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      id_ready = ($urandom % 4) != 0;
      redirect = ($urandom % 12) == 0;
      case ($urandom % 8)
        0:       redirect_pc = ($urandom % 4096) | 32'h1;
        1:       redirect_pc = ($urandom & 32'hFFFF_FFFC) | 32'h1000;
        2:       redirect_pc = 32'hFF0 + 4 * ($urandom % 4);
        default: redirect_pc = 4 * ($urandom % MEM_WORDS);
      endcase
      tick();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        if (errs < 5) $display("FAIL random_cycle%0d got=%h want=%h", i, dut_vec(), model_vec());
        errs++;
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_mid_reset();
    id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (dut_vec() !== {1'b0, 32'h0, NOP, 2'b00, 1'b0, 32'h0, RESET_PC}) begin
      bad++; $display("FAIL mid_reset got=%h want=%h", dut_vec(),
                      {1'b0, 32'h0, NOP, 2'b00, 1'b0, 32'h0, RESET_PC});
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (if_valid !== 1'b0 || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL mid_reset_boot got valid=%b want 0", if_valid);
    end
    tick();
    total++;
    if (if_pc !== RESET_PC || if_instr !== mem[0] || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL mid_reset_restart got pc=%h instr=%h want pc=%h instr=%h",
                      if_pc, if_instr, RESET_PC, mem[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093; mem[1] = 32'h0010_0113;
    mem[2] = 32'h0020_81B3; mem[3] = 32'h0000_0013;
    model_reset();

    test_reset();
    test_program();
    test_backpressure();
    test_redirect();
    test_misaligned_halt();
    test_out_of_range();
    test_random();
    test_mid_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
